// File: rtl/butterfly_r2_pipe_pkg.sv
// Shared widths and arithmetic helpers for the radix-2 butterfly pipeline.
package bfly_pkg;

   localparam int DEF_IN_W  = 13;
   localparam int DEF_FRAC  = 9;
   localparam int DEF_TW_W  = 12;
   localparam int DEF_SCALE = 0;

   // Half an LSB of the post-shift product, giving round-half-up
   function automatic int rnd_const(input int twW);
      return 1 << (twW - 3);
   endfunction

   function automatic int sat_clip(input int x, input int w);
      int maxV;
      int minV;
      maxV = (1 << (w - 1)) - 1;
      minV = -(1 << (w - 1));
      if (x > maxV) return maxV;
      if (x < minV) return minV;
      return x;
   endfunction

endpackage

// File: rtl/butterfly_r2_pipe_if.sv
// Operand, twiddle, result and handshake bundle of the butterfly.
interface butterfly_r2_pipe_if #(
   parameter int IN_W  = 13,
   parameter int TW_W  = 12,
   parameter int OUT_W = 14
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    inverse;
   logic signed [IN_W-1:0]  ui_re;
   logic signed [IN_W-1:0]  ui_im;
   logic signed [IN_W-1:0]  li_re;
   logic signed [IN_W-1:0]  li_im;
   logic signed [TW_W-1:0]  tw_re;
   logic signed [TW_W-1:0]  tw_im;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] uo_re;
   logic signed [OUT_W-1:0] uo_im;
   logic signed [OUT_W-1:0] lo_re;
   logic signed [OUT_W-1:0] lo_im;
   logic                    sat_flag;
   logic                    sat_clr;

   modport slave (
      input  in_valid, inverse, ui_re, ui_im, li_re, li_im, tw_re, tw_im,
      input  out_ready, sat_clr,
      output in_ready, out_valid, uo_re, uo_im, lo_re, lo_im, sat_flag
   );

   modport master (
      output in_valid, inverse, ui_re, ui_im, li_re, li_im, tw_re, tw_im,
      output out_ready, sat_clr,
      input  in_ready, out_valid, uo_re, uo_im, lo_re, lo_im, sat_flag
   );
endinterface

// File: rtl/butterfly_r2_pipe_mult.sv
// Complex multiply LI * W' (W' conjugated for inverse) with round-half-up
// rescaling back to the data format.
module cmplx_mult_rnd
   import bfly_pkg::*;
#(
   parameter int IN_W = DEF_IN_W,
   parameter int TW_W = DEF_TW_W
)(
   input  logic signed [IN_W-1:0] i_liRe,
   input  logic signed [IN_W-1:0] i_liIm,
   input  logic signed [TW_W-1:0] i_twRe,
   input  logic signed [TW_W-1:0] i_twIm,
   input  logic                   i_inverse,
   output logic signed [IN_W+2:0] o_pRe,
   output logic signed [IN_W+2:0] o_pIm
);
   localparam int PW = IN_W + TW_W + 1;
   localparam int SH = TW_W - 2;
   localparam logic signed [PW-1:0] RND = PW'(rnd_const(TW_W));

   logic signed [PW-1:0] w_liRe;
   logic signed [PW-1:0] w_liIm;
   logic signed [PW-1:0] w_twRe;
   logic signed [PW-1:0] w_twIm;
   logic signed [PW-1:0] w_accRe;
   logic signed [PW-1:0] w_accIm;
   logic                 w_unused;

   // Extend before negating so conj of the most negative twiddle stays exact
   assign w_liRe = PW'(i_liRe);
   assign w_liIm = PW'(i_liIm);
   assign w_twRe = PW'(i_twRe);
   assign w_twIm = i_inverse ? -PW'(i_twIm) : PW'(i_twIm);

   assign w_accRe = w_liRe * w_twRe - w_liIm * w_twIm + RND;
   assign w_accIm = w_liRe * w_twIm + w_liIm * w_twRe + RND;

   assign o_pRe    = w_accRe[PW-1:SH];
   assign o_pIm    = w_accIm[PW-1:SH];
   assign w_unused = ^{w_accRe[SH-1:0], w_accIm[SH-1:0]};

endmodule

// File: rtl/butterfly_r2_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: UO = UI + LI*W', LO = UI - LI*W',
// with optional halving, saturation and a sticky saturation flag.
module butterfly_r2_pipe
   import bfly_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int FRAC  = DEF_FRAC,
   parameter int TW_W  = DEF_TW_W,
   parameter int SCALE = DEF_SCALE
)(
   input logic                clk,
   input logic                rst_n,
   butterfly_r2_pipe_if.slave bus
);
   localparam int OUT_W = (SCALE != 0) ? IN_W : IN_W + 1;
   localparam int P_W   = IN_W + 3;
   localparam int SUM_W = IN_W + 4;

   logic                    r_s1Valid;
   logic                    r_s1Inv;
   logic signed [IN_W-1:0]  r_s1UiRe;
   logic signed [IN_W-1:0]  r_s1UiIm;
   logic signed [IN_W-1:0]  r_s1LiRe;
   logic signed [IN_W-1:0]  r_s1LiIm;
   logic signed [TW_W-1:0]  r_s1TwRe;
   logic signed [TW_W-1:0]  r_s1TwIm;

   logic                    r_s2Valid;
   logic signed [IN_W-1:0]  r_s2UiRe;
   logic signed [IN_W-1:0]  r_s2UiIm;
   logic signed [P_W-1:0]   r_s2PRe;
   logic signed [P_W-1:0]   r_s2PIm;

   logic                    r_s3Valid;
   logic signed [OUT_W-1:0] r_s3UoRe;
   logic signed [OUT_W-1:0] r_s3UoIm;
   logic signed [OUT_W-1:0] r_s3LoRe;
   logic signed [OUT_W-1:0] r_s3LoIm;
   logic                    r_satFlag;

   logic                    w_s3Take;
   logic                    w_s2Take;
   logic                    w_s2Adv;
   logic                    w_s1Adv;
   logic                    w_inReady;
   logic                    w_inXfer;
   logic signed [P_W-1:0]   w_pRe;
   logic signed [P_W-1:0]   w_pIm;
   logic signed [SUM_W-1:0] w_sum    [4];
   logic signed [SUM_W-1:0] w_scaled [4];
   int                      w_val    [4];
   int                      w_clip   [4];
   logic                    w_satAny;
   logic                    w_unused;

   // A stage may load when it is empty or its content moves on this edge
   assign w_s3Take  = !r_s3Valid || bus.out_ready;
   assign w_s2Adv   = r_s2Valid && w_s3Take;
   assign w_s2Take  = !r_s2Valid || w_s2Adv;
   assign w_s1Adv   = r_s1Valid && w_s2Take;
   assign w_inReady = !r_s1Valid || w_s1Adv;
   assign w_inXfer  = bus.in_valid && w_inReady;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_s1Inv   <= 1'b0;
         r_s1UiRe  <= '0;
         r_s1UiIm  <= '0;
         r_s1LiRe  <= '0;
         r_s1LiIm  <= '0;
         r_s1TwRe  <= '0;
         r_s1TwIm  <= '0;
      end else begin
         if (w_inReady) r_s1Valid <= bus.in_valid;
         if (w_inXfer) begin
            r_s1Inv  <= bus.inverse;
            r_s1UiRe <= bus.ui_re;
            r_s1UiIm <= bus.ui_im;
            r_s1LiRe <= bus.li_re;
            r_s1LiIm <= bus.li_im;
            r_s1TwRe <= bus.tw_re;
            r_s1TwIm <= bus.tw_im;
         end
      end
   end

   cmplx_mult_rnd #(
      .IN_W (IN_W),
      .TW_W (TW_W)
   ) u_mult (
      .i_liRe    (r_s1LiRe),
      .i_liIm    (r_s1LiIm),
      .i_twRe    (r_s1TwRe),
      .i_twIm    (r_s1TwIm),
      .i_inverse (r_s1Inv),
      .o_pRe     (w_pRe),
      .o_pIm     (w_pIm)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2Valid <= 1'b0;
         r_s2UiRe  <= '0;
         r_s2UiIm  <= '0;
         r_s2PRe   <= '0;
         r_s2PIm   <= '0;
      end else begin
         if (w_s2Take) r_s2Valid <= r_s1Valid;
         if (w_s1Adv) begin
            r_s2UiRe <= r_s1UiRe;
            r_s2UiIm <= r_s1UiIm;
            r_s2PRe  <= w_pRe;
            r_s2PIm  <= w_pIm;
         end
      end
   end

   // Order of components: UO re, UO im, LO re, LO im
   always_comb begin
      w_satAny = 1'b0;
      w_sum[0] = SUM_W'(r_s2UiRe) + SUM_W'(r_s2PRe);
      w_sum[1] = SUM_W'(r_s2UiIm) + SUM_W'(r_s2PIm);
      w_sum[2] = SUM_W'(r_s2UiRe) - SUM_W'(r_s2PRe);
      w_sum[3] = SUM_W'(r_s2UiIm) - SUM_W'(r_s2PIm);
      for (int k = 0; k < 4; k++) begin
         w_scaled[k] = (SCALE != 0) ? ((w_sum[k] + SUM_W'(1)) >>> 1) : w_sum[k];
         w_val[k]    = int'(w_scaled[k]);
         w_clip[k]   = sat_clip(w_val[k], OUT_W);
         if (w_clip[k] != w_val[k]) w_satAny = 1'b1;
      end
   end

   assign w_unused = ^{w_clip[0][31:OUT_W], w_clip[1][31:OUT_W],
                       w_clip[2][31:OUT_W], w_clip[3][31:OUT_W]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s3Valid <= 1'b0;
         r_s3UoRe  <= '0;
         r_s3UoIm  <= '0;
         r_s3LoRe  <= '0;
         r_s3LoIm  <= '0;
      end else begin
         if (w_s3Take) r_s3Valid <= r_s2Valid;
         if (w_s2Adv) begin
            r_s3UoRe <= w_clip[0][OUT_W-1:0];
            r_s3UoIm <= w_clip[1][OUT_W-1:0];
            r_s3LoRe <= w_clip[2][OUT_W-1:0];
            r_s3LoIm <= w_clip[3][OUT_W-1:0];
         end
      end
   end

   // A fresh saturation outranks a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    r_satFlag <= 1'b0;
      else if (w_s2Adv && w_satAny)  r_satFlag <= 1'b1;
      else if (bus.sat_clr)          r_satFlag <= 1'b0;
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = r_s3Valid;
   assign bus.uo_re     = r_s3UoRe;
   assign bus.uo_im     = r_s3UoIm;
   assign bus.lo_re     = r_s3LoRe;
   assign bus.lo_im     = r_s3LoIm;
   assign bus.sat_flag  = r_satFlag;

endmodule

// File: doc/butterfly_r2_pipe.md
BUTTERFLY_R2_PIPE -- requirements
Module: butterfly_r2_pipe

Interface
REQ-001 Parameter IN_W, default 13: signed input width per real/imag component (S3.9 at default).
REQ-002 Parameter FRAC, default 9: fractional bits of the data format, carried unchanged to the output.
REQ-003 Parameter TW_W, default 12: signed twiddle width, format S1.(TW_W-2); +1.0 = 2^(TW_W-2) = 1024 at default.
REQ-004 Parameter SCALE, default 0: 0 = grow one bit, OUT_W = IN_W+1; 1 = divide by 2 with rounding, OUT_W = IN_W.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  input sample pair is valid.
REQ-008 in_ready  output  1  block accepts the pair this cycle.
REQ-009 inverse  input  1  sampled with the inputs; 1 = IFFT, conjugate the twiddle.
REQ-010 ui_re, ui_im, li_re, li_im  input  IN_W each  upper and lower complex operands, signed.
REQ-011 tw_re, tw_im  input  TW_W each  twiddle, signed.
REQ-012 out_valid  output  1  output pair is valid.
REQ-013 out_ready  input  1  downstream accepts the output.
REQ-014 uo_re, uo_im, lo_re, lo_im  output  OUT_W each  signed results.
REQ-015 sat_flag  output  1  sticky flag: saturation occurred.
REQ-016 sat_clr  input  1  synchronous clear of sat_flag.

Function
REQ-017 A transfer occurs on a rising clk edge with in_valid && in_ready; output handoff occurs with out_valid && out_ready.
REQ-018 Pipeline of exactly 3 register stages: S1 registers the operands and inverse; S2 holds the complex product P = LI * W' (W' = conj(W) when inverse=1); S3 holds the butterfly sums. Latency is 3 cycles with no stall.
REQ-019 Product: P_re = li_re*tw_re - li_im*tw_im' and P_im = li_re*tw_im' + li_im*tw_re, computed at full width IN_W+TW_W+1.
REQ-020 Rounding: P is shifted right by TW_W-2 with round-half-up, i.e. 2^(TW_W-3) is added before the shift; the result is held at IN_W+3 bits.
REQ-021 Butterfly: UO = UI + P and LO = UI - P, with UI sign-extended.
REQ-022 SCALE=1: the sum is added to 1 and arithmetically shifted right by 1 before saturation.
REQ-023 Each output component saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any saturated component in a transfer sets sat_flag on the same edge on which S3 loads.
REQ-024 sat_clr clears sat_flag; when a new saturation coincides with sat_clr, set wins.
REQ-025 Backpressure: a stage advances only when the stage downstream of it is empty or advancing. in_ready = !S1_full || S1_advances. No sample is dropped or duplicated.
REQ-026 With out_ready held high, the block sustains one transfer per cycle.
REQ-027 Output data stays stable while out_valid && !out_ready.
REQ-028 The inverse bit travels with its sample; changing it between transfers affects only the samples it accompanied.

Reset
REQ-029 When rst_n is low, all stage valid bits, out_valid and sat_flag clear immediately and asynchronously; data registers reset to 0.
REQ-030 in_ready is 1 from the first edge after rst_n deasserts.
REQ-031 Assertion of rst_n low mid-stream discards all in-flight samples; no output is produced for them after release.

Structure
REQ-032 Shared package bfly_pkg holds the default widths, the rounding constant function and the saturation function.
REQ-033 One sub-module, cmplx_mult_rnd, implements REQ-019 and REQ-020 (combinational, with registering done by the parent S2).

Verification (IN_W=13, FRAC=9, TW_W=12, SCALE=0 unless stated)
REQ-034 UI=(512,0), LI=(256,0), W=(1024,0), inverse=0 -> 3 cycles later UO=(768,0), LO=(256,0).
REQ-035 UI=(512,0), LI=(256,0), W=(0,-1024): inverse=0 -> UO=(512,-256), LO=(512,256); same stimulus with inverse=1 -> UO=(512,256), LO=(512,-256).
REQ-036 UI=(4095,4095), LI=(4095,4095), W=(1024,1024) -> UO_im saturates to 8191, sat_flag=1; it stays 1 until sat_clr.
REQ-037 SCALE=1: UI=(3,0), LI=(0,0), W=(1024,0) -> UO=(2,0), LO=(2,0).
REQ-038 Send 6 back-to-back samples with out_ready low for cycles 2-7 -> in_ready drops after 3 accepted; all 6 outputs emerge in order, unchanged.
REQ-039 Drop rst_n while 2 samples are in flight -> out_valid=0 at once; after release the next input yields exactly one output.
